mul_div_unit: RTL

Parametrised iterative multiply/divide unit with its own HI/LO result registers, the multi-cycle companion to the single-cycle ALU in the datapath library. It executes signed/unsigned multiply and divide over N-bit operands, one iteration per clock, and signals completion with a start/busy/done handshake. The pipeline control stalls dependent HI/LO reads on `busy`. HI/LO can also be written directly (mthi/mtlo).

---
 rtl/mul_div_unit_if.sv | 28 ++
 rtl/mul_div_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The master issues operations and direct HI/LO writes; the slave returns status and HI/LO.
interface mul_div_unit_if #(
    parameter int N = 32
);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] inA;
    logic [N-1:0] inB;
    logic         hi_wen;
    logic         lo_wen;
    logic [N-1:0] wd;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [N-1:0] hi;
    logic [N-1:0] lo;

    modport master (
        output start, op, inA, inB, hi_wen, lo_wen, wd,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, inA, inB, hi_wen, lo_wen, wd,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative signed/unsigned multiply and restoring divide, one bit per clock,
// with HI/LO result registers that also accept direct writes while idle.
module mul_div_unit #(
    parameter int N = 32
) (
    input  logic           clock,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    // Magnitude of a possibly signed operand; the most negative value maps to itself,
    // which is still the correct unsigned magnitude.
    function automatic logic [N-1:0] mag(input logic [N-1:0] v, input logic sgn);
        if (sgn && v[N-1]) begin
            mag = ~v + {{(N-1){1'b0}}, 1'b1};
        end else begin
            mag = v;
        end
    endfunction

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [N-1:0]   opnd_q, opnd_d;
    logic           is_div_q, is_div_d;
    logic           neg_res_q, neg_res_d;
    logic           neg_rem_q, neg_rem_d;
    logic           dbz_q, dbz_d;
    logic [N-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           div_by_zero_q, div_by_zero_d;

    logic           signed_op_s;
    logic           a_neg_s;
    logic           b_neg_s;
    logic [N-1:0]   a_mag_s;
    logic [N-1:0]   b_mag_s;
    logic [N:0]     mul_sum_s;
    logic [N:0]     div_shift_s;
    logic           div_ge_s;
    logic [N-1:0]   div_diff_s;
    logic [N-1:0]   quo_s;
    logic [N-1:0]   rem_s;
    logic [2*N-1:0] prod_s;

    // Operand decode and one iteration of each datapath.
    always_comb begin
        signed_op_s = ~bus.op[0];
        a_neg_s     = signed_op_s & bus.inA[N-1];
        b_neg_s     = signed_op_s & bus.inB[N-1];
        a_mag_s     = mag(bus.inA, signed_op_s);
        b_mag_s     = mag(bus.inB, signed_op_s);
        // acc = {partial product, remaining multiplier bits}; add then shift right.
        mul_sum_s   = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
        // acc = {remainder, remaining dividend bits / quotient bits}; shift left then trial subtract.
        div_shift_s = {acc_q[2*N-1:N], acc_q[N-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_q});
        div_diff_s  = div_shift_s[N-1:0] - opnd_q;
        quo_s       = neg_res_q ? (~acc_q[N-1:0] + {{(N-1){1'b0}}, 1'b1}) : acc_q[N-1:0];
        rem_s       = neg_rem_q ? (~acc_q[2*N-1:N] + {{(N-1){1'b0}}, 1'b1}) : acc_q[2*N-1:N];
        prod_s      = neg_res_q ? (~acc_q + {{(2*N-1){1'b0}}, 1'b1}) : acc_q;
    end

    // Next-state logic for the controller, the datapath and HI/LO.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        opnd_d        = opnd_q;
        is_div_d      = is_div_q;
        neg_res_d     = neg_res_q;
        neg_rem_d     = neg_rem_q;
        dbz_d         = dbz_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        done_d        = 1'b0;
        div_by_zero_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    is_div_d  = bus.op[1];
                    neg_res_d = a_neg_s ^ b_neg_s;
                    neg_rem_d = a_neg_s;
                    cnt_d     = CW'(N - 1);
                    if (bus.op[1] && (bus.inB == {N{1'b0}})) begin
                        dbz_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = S_CALC;
                    end
                    if (bus.op[1]) begin
                        acc_d  = {{N{1'b0}}, a_mag_s};
                        opnd_d = b_mag_s;
                    end else begin
                        acc_d  = {{N{1'b0}}, b_mag_s};
                        opnd_d = a_mag_s;
                    end
                end else begin
                    if (bus.hi_wen) begin
                        hi_d = bus.wd;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (bus.lo_wen) begin
                        lo_d = bus.wd;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    acc_d = div_ge_s ? {div_diff_s, acc_q[N-2:0], 1'b1}
                                     : {div_shift_s[N-1:0], acc_q[N-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum_s, acc_q[N-1:1]};
                end
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_FIN: begin
                state_d       = S_IDLE;
                done_d        = 1'b1;
                div_by_zero_d = dbz_q;
                if (dbz_q) begin
                    hi_d = hi_q;
                    lo_d = lo_q;
                end else if (is_div_q) begin
                    hi_d = rem_s;
                    lo_d = quo_s;
                end else begin
                    hi_d = prod_s[2*N-1:N];
                    lo_d = prod_s[N-1:0];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= {CW{1'b0}};
            acc_q         <= {(2*N){1'b0}};
            opnd_q        <= {N{1'b0}};
            is_div_q      <= 1'b0;
            neg_res_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            dbz_q         <= 1'b0;
            hi_q          <= {N{1'b0}};
            lo_q          <= {N{1'b0}};
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            opnd_q        <= opnd_d;
            is_div_q      <= is_div_d;
            neg_res_q     <= neg_res_d;
            neg_rem_q     <= neg_rem_d;
            dbz_q         <= dbz_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = div_by_zero_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule
